// File: rtl/capi_dma_ltag_alloc.sv
// Local read-data tag (ltag) pool allocator: round-robin arbitration between
// requesters, lowest-free-tag selection, registered grant stage and tag return.
module capi_dma_ltag_alloc #(
    parameter int ways       = 2,
    parameter int ltag_width = 6,
    parameter int cnt_width  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ways-1:0]       i_v,
    output logic [ways-1:0]       i_r,
    output logic                  o_v,
    input  logic                  o_r,
    output logic [ltag_width-1:0] o_ltag,
    output logic [ways-1:0]       o_sel,
    input  logic                  i_free_v,
    input  logic [ltag_width-1:0] i_free_ltag,
    output logic [cnt_width-1:0]  o_free_cnt,
    output logic                  o_empty,
    output logic                  o_err
);

    localparam int pool     = 1 << ltag_width;
    localparam int rr_width = (ways > 1) ? $clog2(ways) : 1;

    logic [pool-1:0]       fb_reg;
    logic [pool-1:0]       fb_next;
    logic [rr_width-1:0]   rr_reg;
    logic                  o_v_reg;
    logic [ltag_width-1:0] ltag_reg;
    logic [ways-1:0]       sel_reg;
    logic [cnt_width-1:0]  cnt_reg;
    logic [cnt_width-1:0]  cnt_next;
    logic                  err_reg;

    logic                  ld;
    logic                  accept;
    logic                  win_found;
    logic [rr_width-1:0]   win_idx;
    logic [ways-1:0]       win_oh;
    logic [ltag_width-1:0] alloc_idx;
    logic [pool-1:0]       alloc_dec;
    logic [pool-1:0]       free_dec;
    logic                  free_ok;
    logic                  free_dbl;

    assign ld      = !o_v_reg || o_r;
    assign o_empty = (cnt_reg == '0);
    assign accept  = ld && !o_empty && win_found;

    // Round robin: prefer the first requester above the last winner, else wrap
    // around to the lowest-numbered active requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int j = 0; j < ways; j++) begin
            if (!win_found && i_v[j] && (j > int'(rr_reg))) begin
                win_found = 1'b1;
                win_idx   = j[rr_width-1:0];
            end
        end
        for (int j = 0; j < ways; j++) begin
            if (!win_found && i_v[j]) begin
                win_found = 1'b1;
                win_idx   = j[rr_width-1:0];
            end
        end
        for (int j = 0; j < ways; j++) begin
            if (win_found && (win_idx == j[rr_width-1:0])) begin
                win_oh[j] = 1'b1;
            end
        end
    end

    // Lowest-numbered free tag; scanning downward lets the last hit win.
    always_comb begin
        alloc_idx = '0;
        for (int i = pool - 1; i >= 0; i--) begin
            if (fb_reg[i]) begin
                alloc_idx = i[ltag_width-1:0];
            end
        end
    end

    assign free_ok   = i_free_v && !fb_reg[i_free_ltag];
    assign free_dbl  = i_free_v && fb_reg[i_free_ltag];
    assign alloc_dec = accept  ? (pool'(1) << alloc_idx)   : '0;
    assign free_dec  = free_ok ? (pool'(1) << i_free_ltag) : '0;

    // Allocated and returned tags never coincide: one is free, the other busy.
    genvar gi;
    generate
        for (gi = 0; gi < pool; gi++) begin : g_fb
            assign fb_next[gi] = (fb_reg[gi] & ~alloc_dec[gi]) | free_dec[gi];
        end
        for (gi = 0; gi < ways; gi++) begin : g_ir
            assign i_r[gi] = accept & win_oh[gi];
        end
    endgenerate

    assign cnt_next = cnt_reg - cnt_width'(accept) + cnt_width'(free_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_reg   <= '1;
            rr_reg   <= rr_width'(ways - 1);
            o_v_reg  <= 1'b0;
            ltag_reg <= '0;
            sel_reg  <= '0;
            cnt_reg  <= cnt_width'(pool);
            err_reg  <= 1'b0;
        end else begin
            fb_reg  <= fb_next;
            cnt_reg <= cnt_next;
            if (free_dbl) begin
                err_reg <= 1'b1;
            end
            if (ld) begin
                o_v_reg <= accept;
                if (accept) begin
                    ltag_reg <= alloc_idx;
                    sel_reg  <= win_oh;
                    rr_reg   <= win_idx;
                end
            end
        end
    end

    assign o_v        = o_v_reg;
    assign o_ltag     = ltag_reg;
    assign o_sel      = sel_reg;
    assign o_free_cnt = cnt_reg;
    assign o_err      = err_reg;

endmodule
